// File: rtl/rv32v_alu_pkg.sv
// Shared op-class codes, sequencer states and op classification helpers for the ALU operand-select path.
// Op codes double as the operand-select mux encoding.
package rv32v_alu_pkg;

    localparam logic [2:0] OP_RR = 3'b000;
    localparam logic [2:0] OP_RI = 3'b001;
    localparam logic [2:0] OP_VV = 3'b010;
    localparam logic [2:0] OP_VI = 3'b011;
    localparam logic [2:0] OP_LS = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAL = 2'b01,
        ST_VEC  = 2'b10,
        ST_FIN  = 2'b11
    } state_t;

    function automatic logic is_vec(input logic [2:0] op);
        return (op == OP_VV) || (op == OP_VI);
    endfunction

    function automatic logic is_legal(input logic [2:0] op);
        return (op == OP_RR) || (op == OP_RI) || (op == OP_VV) ||
               (op == OP_VI) || (op == OP_LS);
    endfunction

endpackage

// File: rtl/vec_elem_cnt.sv
// Element index counter: load arms a new length, en advances, last flags the final element.
// Latency: registered, one cycle from load/en/clr. Backpressure: caller gates en with stall.
// Holds all state whenever load/en/clr are low.
module vec_elem_cnt #(
    parameter int NUM_ELEM = 8,
    parameter int EW       = $clog2(NUM_ELEM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic          en,
    input  logic [EW:0]   vl,
    output logic [EW-1:0] idx,
    output logic          last
);

    logic [EW:0] vl_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            idx  <= '0;
            last <= 1'b0;
            vl_q <= '0;
        end else if (load) begin
            idx  <= '0;
            vl_q <= vl;
            last <= (vl == (EW+1)'(1));
        end else if (en) begin
            idx  <= idx + 1'b1;
            // next index is idx+1, which is the last one when idx+2 == vl
            last <= (({1'b0, idx} + (EW+1)'(2)) == vl_q);
        end
    end

endmodule

// File: rtl/alu_opsel_seq.sv
// Operand-select sequencer: drives mux enable/select for one decoded op, stepping vector elements.
// Latency: accept T, first stg_en T+1, done T+1+N, ready again T+2+N.
// Backpressure: in_ready only in IDLE; stall freezes sequencing and drops stg_en; flush aborts.
module alu_opsel_seq
    import rv32v_alu_pkg::*;
#(
    parameter int NUM_ELEM = 8,
    parameter int EW       = $clog2(NUM_ELEM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [EW:0]   in_vl,
    input  logic          stall,
    input  logic          flush,
    output logic          stg_en,
    output logic [2:0]    select,
    output logic [EW-1:0] elem_idx,
    output logic          last,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t      state;
    logic        accept;
    logic [EW:0] vl_clamp;
    logic        cnt_load;
    logic        cnt_en;
    logic        cnt_clr;
    logic [EW:0] cnt_vl;

    assign in_ready = (state == ST_IDLE) && !flush;
    assign stg_en   = ((state == ST_SCAL) || (state == ST_VEC)) && !stall;
    assign busy     = (state != ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign vl_clamp = (in_vl > (EW+1)'(NUM_ELEM)) ? (EW+1)'(NUM_ELEM) : in_vl;

    // Scalar ops load a length of one so the counter's last flag covers them too.
    always_comb begin
        cnt_load = accept && is_legal(in_op) && (!is_vec(in_op) || (in_vl != '0));
        cnt_vl   = is_vec(in_op) ? vl_clamp : (EW+1)'(1);
        cnt_clr  = flush || (stg_en && last);
        cnt_en   = stg_en && !last;
    end

    vec_elem_cnt #(
        .NUM_ELEM (NUM_ELEM),
        .EW       (EW)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .load (cnt_load),
        .en   (cnt_en),
        .vl   (cnt_vl),
        .idx  (elem_idx),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            select <= OP_RR;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (in_valid) begin
                            if (!is_legal(in_op)) begin
                                state <= ST_FIN;
                                done  <= 1'b1;
                                err   <= 1'b1;
                            end else begin
                                select <= in_op;
                                if (!is_vec(in_op)) begin
                                    state <= ST_SCAL;
                                end else if (in_vl == '0) begin
                                    state <= ST_FIN;
                                    done  <= 1'b1;
                                end else begin
                                    state <= ST_VEC;
                                end
                            end
                        end
                    end
                    ST_SCAL, ST_VEC: begin
                        if (!stall && last) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end
                    end
                    ST_FIN:  state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
